// File: rtl/fc_pkg.sv
// Shared Fibre Channel definitions: port states, primitive classes and the
// ordered-set words used to recognize them on the receive stream.
package fc;

  typedef enum logic [3:0] {
    STATE_AC  = 4'd0,
    STATE_LR1 = 4'd1,
    STATE_LR2 = 4'd2,
    STATE_LR3 = 4'd3,
    STATE_OL1 = 4'd4,
    STATE_OL2 = 4'd5,
    STATE_OL3 = 4'd6,
    STATE_LF1 = 4'd7,
    STATE_LF2 = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    PRIM_NONE = 3'd0,
    PRIM_OLS  = 3'd1,
    PRIM_NOS  = 3'd2,
    PRIM_LR   = 3'd3,
    PRIM_LRR  = 3'd4,
    PRIM_IDLE = 3'd5
  } prim_t;

  // Ordered sets as they appear on the 32-bit bus, K28.5 in byte 3.
  localparam logic [31:0] OLS_WORD  = 32'hBC35_8A55;
  localparam logic [31:0] NOS_WORD  = 32'hBC55_BF45;
  localparam logic [31:0] LR_WORD   = 32'hBC49_BF49;
  localparam logic [31:0] LRR_WORD  = 32'hBC35_BF49;
  localparam logic [31:0] IDLE_WORD = 32'hBC95_B5B5;
  localparam logic [3:0]  PRIM_DATAK = 4'b1000;

  function automatic prim_t classify(input logic [31:0] data, input logic [3:0] datak);
    prim_t p;
    p = PRIM_NONE;
    if (datak == PRIM_DATAK) begin
      case (data)
        OLS_WORD:  p = PRIM_OLS;
        NOS_WORD:  p = PRIM_NOS;
        LR_WORD:   p = PRIM_LR;
        LRR_WORD:  p = PRIM_LRR;
        IDLE_WORD: p = PRIM_IDLE;
        default:   p = PRIM_NONE;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/fc_state_rx_prim_detect.sv
// Primitive-sequence detector: classifies each valid receive word and flags a
// primitive once SEQ_COUNT identical ordered sets have arrived back to back.
module fc_prim_detect
  import fc::*;
#(
  parameter int SEQ_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic        rx_valid,
  input  logic        hold,
  output prim_t       prim,
  output logic        prim_valid
);

  localparam logic [3:0] SEQ_LAST = 4'(SEQ_COUNT);

  prim_t      cls;
  prim_t      last_cls;
  logic [3:0] run_cnt;
  logic [3:0] run_next;

  always_comb begin
    cls      = classify(rx_data, rx_datak);
    run_next = run_cnt;
    if (cls != last_cls || run_cnt == 4'd0) begin
      run_next = 4'd1;
    end else if (run_cnt < SEQ_LAST) begin
      run_next = run_cnt + 4'd1;
    end
  end

  // The run survives rx_valid gaps; only a different class restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cls   <= PRIM_NONE;
      run_cnt    <= 4'd0;
      prim       <= PRIM_NONE;
      prim_valid <= 1'b0;
    end else if (hold) begin
      last_cls   <= PRIM_NONE;
      run_cnt    <= 4'd0;
      prim       <= PRIM_NONE;
      prim_valid <= 1'b0;
    end else if (rx_valid) begin
      last_cls   <= cls;
      run_cnt    <= run_next;
      prim       <= cls;
      prim_valid <= (cls != PRIM_NONE) && (run_next == SEQ_LAST);
    end else begin
      prim_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fc_state_rx.sv
// Fibre Channel link-initialization state machine for one port: tracks the
// port state from recognized primitive sequences, sync loss, timeouts and host requests.
module fc_state_rx
  import fc::*;
#(
  parameter int SEQ_COUNT        = 3,
  parameter int SYNC_LOSS_CYCLES = 64,
  parameter int TIMEOUT_CYCLES   = 10_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic        rx_valid,
  input  logic        rx_sync,
  input  logic        link_reset_req,
  input  logic        offline_req,
  output state_t      state,
  output logic        state_changed,
  output logic        link_up,
  output logic [15:0] link_fail_count
);

  localparam int SW = $clog2(SYNC_LOSS_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SYNC_MAX  = SW'(SYNC_LOSS_CYCLES);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LOSS_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  prim_t         prim;
  logic          prim_valid;
  logic [SW-1:0] sync_cnt;
  logic          sync_lost;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;
  state_t        next_state;
  logic          rx_ols, rx_nos, rx_lr, rx_lrr, rx_idle;

  fc_prim_detect #(
    .SEQ_COUNT(SEQ_COUNT)
  ) u_prim_detect (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_datak   (rx_datak),
    .rx_valid   (rx_valid),
    .hold       (!rx_sync),
    .prim       (prim),
    .prim_valid (prim_valid)
  );

  assign rx_ols  = prim_valid && (prim == PRIM_OLS);
  assign rx_nos  = prim_valid && (prim == PRIM_NOS);
  assign rx_lr   = prim_valid && (prim == PRIM_LR);
  assign rx_lrr  = prim_valid && (prim == PRIM_LRR);
  assign rx_idle = prim_valid && (prim == PRIM_IDLE);

  // sync_lost is registered, so it reaches the FSM one edge after the last low sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_cnt  <= '0;
      sync_lost <= 1'b0;
    end else if (rx_sync) begin
      sync_cnt  <= '0;
      sync_lost <= 1'b0;
    end else begin
      if (sync_cnt != SYNC_MAX) begin
        sync_cnt <= sync_cnt + SW'(1);
      end
      sync_lost <= (sync_cnt >= SYNC_LAST);
    end
  end

  assign timeout = (state != STATE_AC) && (tmo_cnt == TMO_LAST);

  always_comb begin
    next_state = state;
    if (offline_req) begin
      next_state = STATE_OL3;
    end else if (sync_lost || timeout) begin
      next_state = STATE_LF2;
    end else begin
      case (state)
        STATE_AC: begin
          if (rx_lr)               next_state = STATE_LR2;
          else if (rx_ols)         next_state = STATE_OL2;
          else if (rx_nos)         next_state = STATE_LF1;
          else if (link_reset_req) next_state = STATE_LR1;
        end
        STATE_LR1: begin
          if (rx_lrr)      next_state = STATE_LR3;
          else if (rx_lr)  next_state = STATE_LR2;
          else if (rx_ols) next_state = STATE_OL2;
          else if (rx_nos) next_state = STATE_LF1;
        end
        STATE_LR2: begin
          if (rx_lrr)       next_state = STATE_LR3;
          else if (rx_idle) next_state = STATE_AC;
          else if (rx_ols)  next_state = STATE_OL2;
          else if (rx_nos)  next_state = STATE_LF1;
        end
        STATE_LR3: begin
          if (rx_idle)     next_state = STATE_AC;
          else if (rx_lr)  next_state = STATE_LR2;
          else if (rx_ols) next_state = STATE_OL2;
          else if (rx_nos) next_state = STATE_LF1;
        end
        STATE_OL1: begin
          if (rx_ols)      next_state = STATE_OL2;
          else if (rx_lr)  next_state = STATE_LR2;
          else if (rx_nos) next_state = STATE_LF1;
        end
        STATE_OL2: begin
          if (rx_lr)       next_state = STATE_LR2;
          else if (rx_lrr) next_state = STATE_LR3;
          else if (rx_nos) next_state = STATE_LF1;
        end
        // offline_req is already known low here.
        STATE_OL3: next_state = STATE_OL1;
        STATE_LF1: begin
          if (rx_ols)     next_state = STATE_OL2;
          else if (rx_lr) next_state = STATE_LR2;
        end
        STATE_LF2: begin
          if (rx_nos)      next_state = STATE_LF1;
          else if (rx_ols) next_state = STATE_OL2;
        end
        default: next_state = STATE_LF2;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= STATE_LF2;
      state_changed   <= 1'b0;
      link_up         <= 1'b0;
      link_fail_count <= 16'd0;
      tmo_cnt         <= '0;
    end else begin
      state         <= next_state;
      state_changed <= (next_state != state);
      link_up       <= (next_state == STATE_AC);
      if (next_state == STATE_LF2 && state != STATE_LF2 && link_fail_count != 16'hFFFF) begin
        link_fail_count <= link_fail_count + 16'd1;
      end
      // A firing timeout restarts the count even when it resolves to a self-transition.
      if (next_state != state || state == STATE_AC || timeout) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule
